// File: rtl/uart_rx_frame_if.sv
// uart_rx_frame_if: receiver-to-decoder result bundle
//   master: driven by uart_rx_frame
//   slave : seen by the command decoder
//   rx_valid   1-cycle pulse, the other fields were just updated
//   rx_byte    last received data word, LSB = first bit on the wire
//   frame_err  last frame had a stop bit sampled low
//   parity_err last frame failed the parity check
//   busy       receiver is inside a frame
interface uart_rx_frame_if #(parameter int DATA_BITS = 8);
    logic                 rx_valid;
    logic [DATA_BITS-1:0] rx_byte;
    logic                 frame_err;
    logic                 parity_err;
    logic                 busy;
    modport master(output rx_valid, rx_byte, frame_err, parity_err, busy);
    modport slave(input rx_valid, rx_byte, frame_err, parity_err, busy);
endinterface

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: UART receiver with false-start rejection, 3-sample majority vote,
//   framing and optional parity checking.
//   Optional feature macro: UART_RX_PARITY_EN (one parity bit after the data).
//   sys_clk    system clock, rising edge
//   sys_rst_n  asynchronous active-low reset
//   rx_data    asynchronous serial line, idles high
//   rx_if      result bundle (master): rx_valid, rx_byte, frame_err, parity_err, busy
module uart_rx_frame #(
    parameter int CLK_FRE    = 50,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              rx_data,
    uart_rx_frame_if.master   rx_if
);
    localparam int BAUD_MAX = CLK_FRE * 1000000 / BAUD_RATE;
    localparam int MID      = BAUD_MAX / 2;
    localparam int CW       = $clog2(BAUD_MAX);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t               state;
    logic [1:0]           sync;
    logic                 rx_d;
    logic [CW-1:0]        b_cnt;
    logic [3:0]           cnt;
    logic [1:0]           smp;
    logic [DATA_BITS-1:0] shreg;
    logic                 ferr;
`ifdef UART_RX_PARITY_EN
    logic                 par;
`endif

    logic rx_s, vote, b_dec, b_end;
    assign rx_s  = sync[1];
    assign vote  = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);
    assign b_dec = b_cnt == CW'(MID + 1);
    assign b_end = b_cnt == CW'(BAUD_MAX - 1);
    assign rx_if.busy = state != IDLE;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync             <= 2'b11;
            rx_d             <= 1'b1;
            state            <= IDLE;
            b_cnt            <= '0;
            cnt              <= '0;
            smp              <= '0;
            shreg            <= '0;
            ferr             <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par              <= 1'b0;
`endif
            rx_if.rx_valid   <= 1'b0;
            rx_if.rx_byte    <= '0;
            rx_if.frame_err  <= 1'b0;
            rx_if.parity_err <= 1'b0;
        end else begin
            sync           <= {sync[0], rx_data};
            rx_d           <= rx_s;
            rx_if.rx_valid <= 1'b0;
            // held at 0 while idle, so it is cleared on entry to START
            b_cnt <= (state == IDLE || b_end) ? '0 : b_cnt + 1'b1;
            if (b_cnt == CW'(MID - 1)) smp[0] <= rx_s;
            if (b_cnt == CW'(MID)) smp[1] <= rx_s;
            case (state)
                IDLE: if (rx_d && !rx_s) begin
                    state <= START;
                    ferr  <= 1'b0;
                end
                START: if (b_dec && vote) state <= IDLE;
                else if (b_end) begin
                    state <= DATA;
                    cnt   <= '0;
                end
                DATA: begin
                    if (b_dec) shreg <= {vote, shreg[DATA_BITS-1:1]};
                    if (b_end) begin
                        cnt <= (cnt == 4'(DATA_BITS - 1)) ? '0 : cnt + 1'b1;
`ifdef UART_RX_PARITY_EN
                        if (cnt == 4'(DATA_BITS - 1)) state <= PARITY;
`else
                        if (cnt == 4'(DATA_BITS - 1)) state <= STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (b_dec) par <= vote;
                    if (b_end) state <= STOP;
                end
`endif
                STOP: if (b_dec) begin
                    // leave on the last vote, without waiting for bit end, to catch back-to-back frames
                    if (cnt == 4'(STOP_BITS - 1)) begin
                        state            <= IDLE;
                        rx_if.rx_valid   <= 1'b1;
                        rx_if.rx_byte    <= shreg;
                        rx_if.frame_err  <= ferr | ~vote;
`ifdef UART_RX_PARITY_EN
                        rx_if.parity_err <= ((^shreg) ^ par) != 1'(PARITY_ODD);
`else
                        rx_if.parity_err <= 1'b0;
`endif
                    end else ferr <= ferr | ~vote;
                end else if (b_end) cnt <= cnt + 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
